regfile_sb: RTL and testbench

Parametrised successor to the single-write, two-read 16-bit register file.
- Generalises data width, register count and number of read ports.
- Register 0 is hardwired to zero.
- Adds same-cycle write-to-read bypass.
- Adds a per-register scoreboard of pending writes, used by the issue stage for hazard detection.
- Adds a multi-cycle clear sequencer that sweeps the array without an asynchronous reset.
- Sits between the decode/issue stage and the execute/writeback stage.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/regfile_sb.sv | 112 +++++++++++
 tb/tb_regfile_sb.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file types and defaults, also imported by the decode stage.
package regfile_pkg;

   typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t;

   localparam int RF_ZERO_REG = 0;
   localparam int DEF_DATA_W  = 16;
   localparam int DEF_DEPTH   = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write flags with set/clear/sweep updates and
// combinational lookups for each read port.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NUM_RD = 2,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_addr,
   input  logic                     clr_en,
   input  logic [ADDR_W-1:0]        clr_addr,
   input  logic                     sweep_en,
   input  logic [ADDR_W-1:0]        sweep_addr,
   input  logic [NUM_RD*ADDR_W-1:0] lookup_addr,
   output logic [NUM_RD-1:0]        lookup_busy
);

   logic [DEPTH-1:0] busy;

   // Set is applied last so a reservation beats a same-cycle write to that register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy <= '0;
      end else begin
         if (sweep_en)
            busy[sweep_addr] <= 1'b0;
         if (clr_en)
            busy[clr_addr] <= 1'b0;
         if (set_en)
            busy[set_addr] <= 1'b1;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_lookup
      assign lookup_busy[i] = busy[lookup_addr[i*ADDR_W +: ADDR_W]];
   end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised register file with zero register, write-to-read bypass,
// pending-write scoreboard and a sweeping clear sequencer.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int NUM_RD = 2,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_RD-1:0]        rd_en,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_busy,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     rsv_en,
   input  logic [ADDR_W-1:0]        rsv_addr,
   input  logic                     clr_req,
   output logic                     ready
);

   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   rf_state_t         state;
   logic [ADDR_W-1:0] ptr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [NUM_RD-1:0] sb_busy;
   logic              wr_ok;
   logic              rsv_ok;
   logic              sweeping;

   assign wr_ok    = wr_en  && ready && (wr_addr  != ZERO_ADDR);
   assign rsv_ok   = rsv_en && ready && (rsv_addr != ZERO_ADDR);
   assign sweeping = (state == RF_CLEAR);

   // Sweep starts at 1 since register 0 never holds data; ready is registered with the state.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RF_IDLE;
         ptr   <= '0;
         ready <= 1'b1;
      end else begin
         case (state)
            RF_IDLE: begin
               if (clr_req) begin
                  state <= RF_CLEAR;
                  ptr   <= ADDR_W'(1);
                  ready <= 1'b0;
               end
            end
            RF_CLEAR: begin
               if (ptr == LAST_ADDR) begin
                  state <= RF_IDLE;
                  ready <= 1'b1;
               end else begin
                  ptr <= ptr + ADDR_W'(1);
               end
            end
            default: begin
               state <= RF_IDLE;
               ready <= 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < DEPTH; k++)
            mem[k] <= '0;
      end else if (sweeping) begin
         mem[ptr] <= '0;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   regfile_scoreboard #(
      .DEPTH  (DEPTH),
      .NUM_RD (NUM_RD),
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk         (clk),
      .reset       (reset),
      .set_en      (rsv_ok),
      .set_addr    (rsv_addr),
      .clr_en      (wr_ok),
      .clr_addr    (wr_addr),
      .sweep_en    (sweeping),
      .sweep_addr  (ptr),
      .lookup_addr (rd_addr),
      .lookup_busy (sb_busy)
   );

   // A same-cycle accepted write is forwarded and is never reported busy.
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic              live;
      logic              hit;
      assign addr = rd_addr[i*ADDR_W +: ADDR_W];
      assign live = rd_en[i] && (addr != ZERO_ADDR);
      assign hit  = wr_ok && (wr_addr == addr);
      assign rd_data[i*DATA_W +: DATA_W] = !live ? '0 : (hit ? wr_data : mem[addr]);
      assign rd_busy[i] = live && !hit && sb_busy[i];
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: directed vector table, random traffic against a model,
// sweep/reset corner cases and a wide four-port configuration.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  rd_en;
   logic [4:0]  ra0, ra1;
   logic [9:0]  rd_addr;
   logic [31:0] rd_data;
   logic [1:0]  rd_busy;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [15:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic        clr_req;
   logic        ready;

   logic [3:0]   b_rd_en;
   logic [15:0]  b_rd_addr;
   logic [127:0] b_rd_data;
   logic [3:0]   b_rd_busy;
   logic         b_wr_en;
   logic [3:0]   b_wr_addr;
   logic [31:0]  b_wr_data;
   logic         b_rsv_en;
   logic [3:0]   b_rsv_addr;
   logic         b_clr_req;
   logic         b_ready;

   int checks = 0;
   int errors = 0;

   logic [15:0] m_mem [32];
   logic        m_busy [32];
   logic        m_ready;
   int          m_wiped;

   typedef struct {
      logic        wr_en;
      logic [4:0]  wr_addr;
      logic [15:0] wr_data;
      logic        rsv_en;
      logic [4:0]  rsv_addr;
      logic [1:0]  rd_en;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [15:0] d0;
      logic [15:0] d1;
      logic        b0;
      logic        b1;
   } vec_t;

   vec_t vecs [14];

   assign rd_addr = {ra1, ra0};

   always #5 clk = ~clk;

   regfile_sb dut (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (rd_en),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_busy  (rd_busy),
      .wr_en    (wr_en),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rsv_en   (rsv_en),
      .rsv_addr (rsv_addr),
      .clr_req  (clr_req),
      .ready    (ready)
   );

   regfile_sb #(.DATA_W(32), .DEPTH(16), .NUM_RD(4)) dut_wide (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (b_rd_en),
      .rd_addr  (b_rd_addr),
      .rd_data  (b_rd_data),
      .rd_busy  (b_rd_busy),
      .wr_en    (b_wr_en),
      .wr_addr  (b_wr_addr),
      .wr_data  (b_wr_data),
      .rsv_en   (b_rsv_en),
      .rsv_addr (b_rsv_addr),
      .clr_req  (b_clr_req),
      .ready    (b_ready)
   );

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int k = 0; k < 32; k++) begin
         m_mem[k]  = '0;
         m_busy[k] = 1'b0;
      end
      m_ready = 1'b1;
      m_wiped = 0;
   endfunction

   // Expected read on one port from the architectural rules.
   function automatic void model_read(input int p, output logic [15:0] d, output logic b);
      logic [4:0] a;
      a = (p == 0) ? ra0 : ra1;
      d = '0;
      b = 1'b0;
      if (rd_en[p] && a != 0) begin
         if (wr_en && m_ready && wr_addr == a) begin
            d = wr_data;
         end else begin
            d = m_mem[a];
            b = m_busy[a];
         end
      end
   endfunction

   function automatic void model_update();
      if (m_ready) begin
         if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr]  = wr_data;
            m_busy[wr_addr] = 1'b0;
         end
         if (rsv_en && rsv_addr != 0)
            m_busy[rsv_addr] = 1'b1;
         if (clr_req) begin
            m_ready = 1'b0;
            m_wiped = 0;
         end
      end else begin
         m_wiped++;
         m_mem[m_wiped]  = '0;
         m_busy[m_wiped] = 1'b0;
         if (m_wiped == 31)
            m_ready = 1'b1;
      end
   endfunction

   task automatic finishCycle();
      logic [15:0] d;
      logic        b;
      for (int p = 0; p < 2; p++) begin
         model_read(p, d, b);
         checkOutput($sformatf("rd_data%0d", p), 64'(rd_data[p*16 +: 16]), 64'(d));
         checkOutput($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(b));
      end
      checkOutput("ready", 64'(ready), 64'(m_ready));
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic applyStimulus();
      @(negedge clk);
      finishCycle();
   endtask

   task automatic idleInputs();
      wr_en = 0; wr_addr = 0; wr_data = 0;
      rsv_en = 0; rsv_addr = 0; clr_req = 0;
      rd_en = 0; ra0 = 0; ra1 = 0;
      b_wr_en = 0; b_wr_addr = 0; b_wr_data = 0;
      b_rsv_en = 0; b_rsv_addr = 0; b_clr_req = 0;
      b_rd_en = 0; b_rd_addr = 0;
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int n;
      reset = 1'b0;
      idleInputs();
      model_reset();

      vecs[0]  = '{1'b1, 5'd5, 16'hBEEF, 1'b0, 5'd0, 2'b00, 5'd0, 5'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, 5'd7, 16'h1234, 1'b0, 5'd0, 2'b11, 5'd5, 5'd7, 16'hBEEF, 16'h1234, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 2'b11, 5'd5, 5'd5, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, 5'd0, 16'hFFFF, 1'b0, 5'd0, 2'b11, 5'd0, 5'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 2'b11, 5'd0, 5'd7, 16'h0000, 16'h1234, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd0, 2'b01, 5'd0, 5'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 2'b01, 5'd0, 5'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 5'd0, 16'h0000, 1'b1, 5'd9, 2'b10, 5'd0, 5'd9, 16'h0000, 16'h0000, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 2'b10, 5'd0, 5'd9, 16'h0000, 16'h0000, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 5'd9, 16'h00AA, 1'b0, 5'd0, 2'b10, 5'd0, 5'd9, 16'h0000, 16'h00AA, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 2'b10, 5'd0, 5'd9, 16'h0000, 16'h00AA, 1'b0, 1'b0};
      vecs[11] = '{1'b1, 5'd9, 16'h0055, 1'b1, 5'd9, 2'b01, 5'd9, 5'd0, 16'h0055, 16'h0000, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 2'b01, 5'd9, 5'd0, 16'h0055, 16'h0000, 1'b1, 1'b0};
      vecs[13] = '{1'b0, 5'd0, 16'h0000, 1'b0, 5'd0, 2'b10, 5'd9, 5'd5, 16'h0000, 16'hBEEF, 1'b0, 1'b0};

      // Reset state, with reads enabled so the zeroed array is visible.
      repeat (2) @(posedge clk);
      #1;
      rd_en = 2'b11; ra0 = 5'd5; ra1 = 5'd31;
      #1;
      checkOutput("reset_ready", 64'(ready), 64'(1));
      checkOutput("reset_rd_data", 64'(rd_data), 64'(0));
      checkOutput("reset_rd_busy", 64'(rd_busy), 64'(0));
      checkOutput("reset_wide_ready", 64'(b_ready), 64'(1));
      @(posedge clk);
      #1;
      reset = 1'b1;
      idleInputs();

      $display("[TB] directed vector table");
      for (int k = 0; k < 14; k++) begin
         wr_en = vecs[k].wr_en; wr_addr = vecs[k].wr_addr; wr_data = vecs[k].wr_data;
         rsv_en = vecs[k].rsv_en; rsv_addr = vecs[k].rsv_addr;
         rd_en = vecs[k].rd_en; ra0 = vecs[k].ra0; ra1 = vecs[k].ra1;
         @(negedge clk);
         checkOutput($sformatf("vec%0d_d0", k), 64'(rd_data[15:0]), 64'(vecs[k].d0));
         checkOutput($sformatf("vec%0d_d1", k), 64'(rd_data[31:16]), 64'(vecs[k].d1));
         checkOutput($sformatf("vec%0d_b0", k), 64'(rd_busy[0]), 64'(vecs[k].b0));
         checkOutput($sformatf("vec%0d_b1", k), 64'(rd_busy[1]), 64'(vecs[k].b1));
         finishCycle();
      end
      idleInputs();

      $display("[TB] fill and full sweep");
      for (int i = 1; i < 32; i++) begin
         wr_en = 1; wr_addr = 5'(i); wr_data = 16'($urandom_range(1, 16'hFFFF));
         rsv_en = (i % 5 == 0); rsv_addr = 5'(32 - i);
         rd_en = 2'b11; ra0 = 5'(i); ra1 = 5'($urandom_range(0, 31));
         applyStimulus();
      end
      idleInputs();
      clr_req = 1;
      applyStimulus();
      clr_req = 0;
      n = 0;
      while (ready === 1'b0 && n < 100) begin
         wr_en = (n == 5); wr_addr = 5'd3; wr_data = 16'h7777;
         rsv_en = (n == 6); rsv_addr = 5'd4;
         rd_en = 2'b11; ra0 = 5'($urandom_range(0, 31)); ra1 = 5'd3;
         applyStimulus();
         n++;
      end
      checkOutput("sweep_len", 64'(n), 64'(31));
      idleInputs();
      for (int i = 0; i < 16; i++) begin
         rd_en = 2'b11; ra0 = 5'(2*i + 1); ra1 = 5'(2*i + 2);
         @(negedge clk);
         checkOutput($sformatf("swept_d_r%0d", 2*i + 1), 64'(rd_data), 64'(0));
         checkOutput($sformatf("swept_b_r%0d", 2*i + 1), 64'(rd_busy), 64'(0));
         finishCycle();
      end

      $display("[TB] random traffic");
      for (int t = 0; t < 400; t++) begin
         wr_en = 1'($urandom_range(0, 1)); wr_addr = 5'($urandom_range(0, 31));
         wr_data = 16'($urandom);
         rsv_en = ($urandom_range(0, 2) == 0); rsv_addr = 5'($urandom_range(0, 31));
         clr_req = ($urandom_range(0, 79) == 0);
         rd_en = 2'($urandom_range(0, 3));
         ra0 = ($urandom_range(0, 1) == 1) ? wr_addr : 5'($urandom_range(0, 31));
         ra1 = ($urandom_range(0, 1) == 1) ? rsv_addr : 5'($urandom_range(0, 31));
         applyStimulus();
      end
      idleInputs();
      n = 0;
      while (ready === 1'b0 && n < 100) begin
         applyStimulus();
         n++;
      end

      $display("[TB] reset mid-sweep");
      for (int i = 1; i < 32; i++) begin
         wr_en = 1; wr_addr = 5'(i); wr_data = 16'(16'h1000 + i);
         applyStimulus();
      end
      idleInputs();
      clr_req = 1;
      applyStimulus();
      clr_req = 0;
      repeat (11) applyStimulus();
      rd_en = 2'b11; ra0 = 5'd12; ra1 = 5'd30;
      #1;
      checkOutput("pre_reset_r12", 64'(rd_data[15:0]), 64'(16'h100C));
      checkOutput("pre_reset_ready", 64'(ready), 64'(0));
      #1;
      reset = 1'b0;
      #1;
      model_reset();
      checkOutput("midreset_ready", 64'(ready), 64'(1));
      checkOutput("midreset_r12", 64'(rd_data[15:0]), 64'(0));
      checkOutput("midreset_r30", 64'(rd_data[31:16]), 64'(0));
      @(negedge clk);
      reset = 1'b1;
      wr_en = 1; wr_addr = 5'd3; wr_data = 16'h3C3C;
      ra0 = 5'd30; ra1 = 5'd12;
      finishCycle();
      wr_en = 0; ra0 = 5'd3;
      #1;
      checkOutput("post_reset_r3", 64'(rd_data[15:0]), 64'(16'h3C3C));
      applyStimulus();
      checkOutput("post_reset_ready", 64'(ready), 64'(1));

      $display("[TB] wide configuration");
      idleInputs();
      for (int i = 1; i <= 4; i++) begin
         b_wr_en = 1; b_wr_addr = 4'(i); b_wr_data = 32'hCAFE_0000 + 32'(i);
         applyStimulus();
      end
      b_wr_en = 0;
      b_rd_en = 4'hF; b_rd_addr = {4'd4, 4'd3, 4'd2, 4'd1};
      #1;
      for (int p = 0; p < 4; p++) begin
         checkOutput($sformatf("wide_d%0d", p), 64'(b_rd_data[p*32 +: 32]), 64'(32'hCAFE_0000 + 32'(p + 1)));
         checkOutput($sformatf("wide_b%0d", p), 64'(b_rd_busy[p]), 64'(0));
      end
      b_clr_req = 1;
      applyStimulus();
      b_clr_req = 0;
      n = 0;
      while (b_ready === 1'b0 && n < 100) begin
         applyStimulus();
         n++;
      end
      checkOutput("wide_sweep_len", 64'(n), 64'(15));
      checkOutput("wide_cleared", 64'(b_rd_data[63:0]), 64'(0));
      checkOutput("wide_cleared_hi", 64'(b_rd_data[127:64]), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
